// File: rtl/hud_pkg.sv
// ---------------------------------------------------------------------------
// hud_pkg
//   Shared types and constants for the game HUD display stage.
//   - hud_state_e : game status as seen by the HUD (IDLE, RUN, LOSE, WIN)
//   - SEG_*       : 7-segment glyphs, bit order {g,f,e,d,c,b,a}, active-low
//   - popcount6   : number of set bits in a 6-bit brick mask
//   - state_glyph : status glyph shown on the leftmost digit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package hud_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOSE = 2'd2,
        WIN  = 2'd3
    } hud_state_e;

    // Active-low segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_E     = 7'h06;

    function automatic logic [3:0] popcount6(input logic [5:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 6; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [6:0] state_glyph(input hud_state_e s);
        logic [6:0] g;
        case (s)
            IDLE:    g = SEG_DASH;
            RUN:     g = SEG_P;
            WIN:     g = SEG_C;
            LOSE:    g = SEG_E;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
//   Combinational BCD digit to active-low 7-segment pattern.
//   Codes above 9 render blank.
//   i_digit [3:0] : digit value 0..9
//   o_seg   [6:0] : segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_decoder
    import hud_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_hud.sv
// ---------------------------------------------------------------------------
// game_hud
//   Status/score display stage behind the brick_breaker core. Shows elapsed
//   play time MM:SS on hex3..hex0, bricks remaining on hex4 and a status
//   glyph on hex5; blinks the frozen time after win/lose and stretches brick
//   destruction into a visible LED pulse.
//   clk          : system clock
//   rst          : asynchronous reset, active-low
//   start        : start button, active-low, synchronous to clk
//   bricks_exist : per-brick alive flags (1 = alive)
//   game_over    : level, game lost
//   victory      : level, game won
//   hex0..hex5   : registered 7-segment digits, active-low {g,f,e,d,c,b,a}
//   led_hit      : high for HIT_STRETCH cycles after any brick disappears
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module game_hud
    import hud_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int HIT_STRETCH = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bricks_exist,
    input  logic       game_over,
    input  logic       victory,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       led_hit
);

    localparam int PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HIT_W      = $clog2(HIT_STRETCH + 1);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);
    localparam logic [HIT_W-1:0]   HIT_LOAD  = HIT_W'(HIT_STRETCH);

    hud_state_e         r_state;
    hud_state_e         w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [3:0]         r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink;
    logic [HIT_W-1:0]   r_hit_cnt;
    logic [5:0]         r_bricks_prev;
    logic [5:0][6:0]    r_hex;

    logic               w_tick;
    logic               w_tick_eff;
    logic               w_sat;
    logic               w_frozen;
    logic               w_hit;
    logic [4:0][3:0]    w_digit;
    logic [4:0][6:0]    w_seg;
    logic [6:0]         w_glyph;

    // ---------------- status FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Game flags only matter while running; game_over wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (!start) w_state_nxt = RUN;
            RUN: begin
                if (game_over)    w_state_nxt = LOSE;
                else if (victory) w_state_nxt = WIN;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    assign w_frozen = (r_state == LOSE) || (r_state == WIN);

    // ---------------- play timer ----------------
    assign w_tick = (r_state == RUN) && (r_presc == PRESC_MAX);
    // A second that completes on the same edge the game ends is not counted.
    assign w_tick_eff = w_tick && (w_state_nxt == RUN);
    assign w_sat = (r_min_tens == 4'd9) && (r_min_ones == 4'd9) &&
                   (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc    <= '0;
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
        end else begin
            if (r_state == RUN)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            // BCD ripple; 99:59 is a hard ceiling so min_tens never passes 9
            if (w_tick_eff && !w_sat) begin
                if (r_sec_ones != 4'd9) begin
                    r_sec_ones <= r_sec_ones + 4'd1;
                end else begin
                    r_sec_ones <= '0;
                    if (r_sec_tens != 4'd5) begin
                        r_sec_tens <= r_sec_tens + 4'd1;
                    end else begin
                        r_sec_tens <= '0;
                        if (r_min_ones != 4'd9) begin
                            r_min_ones <= r_min_ones + 4'd1;
                        end else begin
                            r_min_ones <= '0;
                            r_min_tens <= r_min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- blink of frozen time ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!w_frozen) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ---------------- brick hit stretcher ----------------
    // Any alive->dead transition (re)loads the stretch counter.
    assign w_hit = |(r_bricks_prev & ~bricks_exist);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bricks_prev <= 6'b111111;
            r_hit_cnt     <= '0;
        end else begin
            r_bricks_prev <= bricks_exist;
            if (w_hit)                 r_hit_cnt <= HIT_LOAD;
            else if (r_hit_cnt != '0)  r_hit_cnt <= r_hit_cnt - 1'b1;
        end
    end

    assign led_hit = (r_hit_cnt != '0);

    // ---------------- digit decode and output registers ----------------
    assign w_digit[0] = r_sec_ones;
    assign w_digit[1] = r_sec_tens;
    assign w_digit[2] = r_min_ones;
    assign w_digit[3] = r_min_tens;
    assign w_digit[4] = popcount6(bricks_exist);
    assign w_glyph    = state_glyph(r_state);

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dec
            seg7_decoder u_dec (
                .i_digit (w_digit[gi]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

    // r_blink can only be set in LOSE/WIN, so it alone gates the time digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hex <= {6{SEG_BLANK}};
        end else begin
            for (int i = 0; i < 4; i++)
                r_hex[i] <= r_blink ? SEG_BLANK : w_seg[i];
            r_hex[4] <= w_seg[4];
            r_hex[5] <= w_glyph;
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

// File: tb/tb_game_hud.sv
`timescale 1ns/1ps
module tb_game_hud;

    localparam int CLK_HZ   = 10;
    localparam int BLINK_HZ = 1;
    localparam int HIT      = 4;
    localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
    localparam int MAX_SECS = 99 * 60 + 59;

    localparam int S_IDLE = 0, S_RUN = 1, S_LOSE = 2, S_WIN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b1;
    logic [5:0] bricks = 6'h3F;
    logic       game_over = 1'b0;
    logic       victory = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       led_hit;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    game_hud #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .HIT_STRETCH(HIT)) dut (
        .clk(clk), .rst(rst), .start(start), .bricks_exist(bricks),
        .game_over(game_over), .victory(victory),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .led_hit(led_hit)
    );

    // ---------------- reference glyph tables ----------------
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input int st);
        case (st)
            S_IDLE: return 7'h3F;
            S_RUN:  return 7'h0C;
            S_LOSE: return 7'h06;
            default: return 7'h46;
        endcase
    endfunction

    function automatic int pop(input logic [5:0] v);
        int n = 0;
        for (int i = 0; i < 6; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time kept as total elapsed seconds; display is derived arithmetically.
    int         m_st, m_presc, m_secs, m_bc, m_hit;
    bit         m_blink;
    logic [5:0] m_prev;
    logic [6:0] e_hex [6];
    bit         e_led;
    int         t_nst, t_min, t_sec, t_hit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= S_IDLE; m_presc <= 0; m_secs <= 0; m_bc <= 0; m_blink <= 1'b0;
            m_hit <= 0; m_prev <= 6'h3F; e_led <= 1'b0;
            for (int i = 0; i < 6; i++) e_hex[i] <= 7'h7F;
        end else begin
            t_min = m_secs / 60;
            t_sec = m_secs % 60;
            e_hex[0] <= m_blink ? 7'h7F : seg(t_sec % 10);
            e_hex[1] <= m_blink ? 7'h7F : seg(t_sec / 10);
            e_hex[2] <= m_blink ? 7'h7F : seg(t_min % 10);
            e_hex[3] <= m_blink ? 7'h7F : seg(t_min / 10);
            e_hex[4] <= seg(pop(bricks));
            e_hex[5] <= glyph(m_st);

            t_nst = m_st;
            if (m_st == S_IDLE && !start) t_nst = S_RUN;
            if (m_st == S_RUN) begin
                if (game_over)    t_nst = S_LOSE;
                else if (victory) t_nst = S_WIN;
            end

            if (m_st == S_RUN) begin
                if (m_presc == CLK_HZ - 1) begin
                    m_presc <= 0;
                    if (t_nst == S_RUN && m_secs < MAX_SECS) m_secs <= m_secs + 1;
                end else begin
                    m_presc <= m_presc + 1;
                end
            end

            if (m_st == S_LOSE || m_st == S_WIN) begin
                if (m_bc == HALF - 1) begin m_bc <= 0; m_blink <= !m_blink; end
                else m_bc <= m_bc + 1;
            end

            t_hit = m_hit;
            if ((m_prev & ~bricks) != 6'h00) t_hit = HIT;
            else if (t_hit > 0)              t_hit = t_hit - 1;
            m_hit  <= t_hit;
            e_led  <= (t_hit != 0);
            m_prev <= bricks;
            m_st   <= t_nst;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en)
            check("outputs{hex5..hex0,led}",
                  {hex5, hex4, hex3, hex2, hex1, hex0, led_hit},
                  {e_hex[5], e_hex[4], e_hex[3], e_hex[2], e_hex[1], e_hex[0], e_led});
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic churn_bricks();
        int r = int'($urandom_range(0, 15));
        if (r == 0)      bricks = 6'($urandom);
        else if (r < 3)  bricks = bricks & ~(6'b1 << $urandom_range(0, 5));
    endtask

    initial begin
        tick(3);
        cmp_en = 1'b1;
        check("reset_blank_hex0", hex0, 7'h7F);
        check("reset_blank_hex5", hex5, 7'h7F);
        tick(2);
        rst = 1'b1;

        // IDLE: time must not move, game flags ignored
        for (int i = 0; i < 50; i++) begin
            game_over = (i >= 20 && i < 30);
            victory   = (i >= 25 && i < 35);
            tick(1);
        end
        check("idle_glyph", hex5, 7'h3F);
        check("idle_sec_ones", hex0, 7'h40);
        check("idle_min_tens", hex3, 7'h40);
        check("idle_bricks6", hex4, 7'h02);
        check("idle_led", led_hit, 1'b0);

        // one-cycle start press, then 605 cycles of RUN
        start = 1'b0; tick(1);
        for (int i = 0; i < 605; i++) begin start = 1'($urandom); tick(1); end
        start = 1'b1;
        check("run_glyph", hex5, 7'h0C);
        check("run_1min_hex3", hex3, 7'h40);
        check("run_1min_hex2", hex2, 7'h79);
        check("run_1min_hex1", hex1, 7'h40);
        check("run_1min_hex0", hex0, 7'h40);

        // hit stretch and retrigger
        bricks = 6'h3E; tick(1);
        check("hit1_led", led_hit, 1'b1);
        check("hit1_bricks5", hex4, 7'h12);
        tick(1);
        bricks = 6'h3C; tick(1);
        check("hit2_led", led_hit, 1'b1);
        check("hit2_bricks4", hex4, 7'h19);
        tick(3);
        check("hit2_led_last", led_hit, 1'b1);
        tick(1);
        check("hit2_led_off", led_hit, 1'b0);

        // random brick churn while running
        for (int i = 0; i < 300; i++) begin churn_bricks(); start = 1'($urandom); tick(1); end

        // simultaneous game_over and victory at 00:07 -> LOSE, frozen + blink
        rst = 1'b0; tick(2); rst = 1'b1; bricks = 6'h3F;
        start = 1'b0; tick(1); start = 1'b1;
        tick(74);
        game_over = 1'b1; victory = 1'b1; tick(1);
        start = 1'b0; tick(1);
        check("lose_glyph", hex5, 7'h06);
        check("lose_frozen_7", hex0, 7'h78);
        tick(5);
        check("lose_blink_off", hex0, 7'h7F);
        tick(5);
        check("lose_blink_on", hex0, 7'h78);
        for (int i = 0; i < 40; i++) begin
            start = 1'($urandom); game_over = 1'($urandom); victory = 1'($urandom);
            churn_bricks(); tick(1);
        end
        check("lose_still_E", hex5, 7'h06);
        game_over = 1'b0; victory = 1'b0; start = 1'b1;

        // long run into the 99:59 ceiling
        rst = 1'b0; tick(2); rst = 1'b1; bricks = 6'h3F;
        start = 1'b0; tick(1);
        for (int i = 0; i < 60050; i++) begin
            start = 1'($urandom);
            if ((i & 63) == 0) churn_bricks();
            tick(1);
        end
        start = 1'b1;
        check("sat_hex3", hex3, 7'h10);
        check("sat_hex2", hex2, 7'h10);
        check("sat_hex1", hex1, 7'h12);
        check("sat_hex0", hex0, 7'h10);

        // victory alone -> WIN
        victory = 1'b1; tick(2);
        check("win_glyph", hex5, 7'h46);
        tick(12);
        victory = 1'b0;

        // async reset mid-run at 00:03 with led active
        rst = 1'b0; tick(2); rst = 1'b1; bricks = 6'h3F;
        start = 1'b0; tick(1); start = 1'b1;
        tick(33);
        bricks = 6'h3E; tick(1);
        #1 rst = 1'b0;
        #1;
        check("async_hex0", hex0, 7'h7F);
        check("async_hex4", hex4, 7'h7F);
        check("async_hex5", hex5, 7'h7F);
        check("async_led", led_hit, 1'b0);
        tick(2);
        start = 1'b0; rst = 1'b1;
        tick(1);
        check("post_reset_idle_glyph", hex5, 7'h3F);
        check("post_reset_sec0", hex0, 7'h40);
        tick(1);
        check("post_reset_rerun", hex5, 7'h0C);
        start = 1'b1;
        tick(20);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
